leitor_letreiro: RTL and testbench
==================================

LEITOR_LETREIRO -- requirements
Module: leitor_letreiro

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single system clock; all state on rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port step, input, 1 bit: one-cycle pulse marking a marquee shift; synchronous to clk.
REQ-004 The module SHALL have port clear, input, 1 bit: synchronous clear of tracking state.
REQ-005 The module SHALL have ports display1..display6, input, 7 bits each: active-low seven-segment patterns; display1 is leftmost.
REQ-006 The module SHALL have ports code1..code6, output, 3 bits each: registered codes decoded from display1..display6; 3'b111 = invalid pattern.
REQ-007 The module SHALL have port pos, output, 3 bits: code shown on display1 while locked.
REQ-008 The module SHALL have port locked, output, 1 bit: rotation sequence recognised and tracking.
REQ-009 The module SHALL have port error, output, 1 bit: sticky sequence violation.
REQ-010 The module SHALL have port rot_count, output, 8 bits: completed revolutions, saturating at 255.

Function
REQ-011 Each pattern SHALL map to codes 0..5 via SEG_TABLE; any other pattern SHALL map to 3'b111.
REQ-012 For a step sampled high in cycle n, code1..code6 SHALL update at edge n+1, and pos/locked/error/rot_count SHALL update at edge n+2.
REQ-013 A step arriving at edge n+1 (compare pending) SHALL be ignored.
REQ-014 A capture is "consecutive" when all codes are valid and code(i+1) = (code(i)+1) mod 6 for i=1..5.
REQ-015 The FSM SHALL have states IDLE, TRACK and FAULT.
REQ-016 In IDLE, a consecutive capture SHALL go to TRACK with pos=code1 and locked=1; any other capture SHALL stay in IDLE with no flag change.
REQ-017 In TRACK, a rotation capture SHALL set pos=(pos+5) mod 6; a rotation capture is consecutive with code1=(pos+5) mod 6.
REQ-018 In TRACK, a reload capture (consecutive, code1=0, not a rotation) SHALL set pos=0 without counting.
REQ-019 Rotation SHALL take priority over reload when both match (pos=1).
REQ-020 rot_count SHALL increment only on a rotation from pos=0 to pos=5, saturating at 255.
REQ-021 In TRACK, any other capture SHALL go to FAULT with error=1 and locked=0; pos and rot_count SHALL hold.
REQ-022 FAULT SHALL ignore step and SHALL be left only via clear or rst_n.
REQ-023 clear SHALL return the FSM to IDLE next edge, zero pos/locked/error/rot_count and codes to 3'b111, and discard any pending compare.
REQ-024 When clear and step are simultaneous, clear SHALL win and the step SHALL be discarded.

Reset
REQ-025 While rst_n=0, the FSM SHALL be in IDLE with code1..code6=3'b111, pos=0, locked=0, error=0, rot_count=0, and the pending compare cleared.
REQ-026 Reset asserted mid-compare SHALL abort the compare; no flag SHALL update from it.

Structure
REQ-027 Package letreiro_pkg SHALL hold SEG_TABLE[0:5], CODE_INVALID=3'b111, N_DISP=6 and the FSM state typedef; the marquee decoder SHALL share SEG_TABLE.
REQ-028 One sub-module, seg_encoder (7-bit pattern -> 3-bit code, combinational), SHALL be instantiated six times.

Verification
REQ-029 Reset, then step with displays showing codes 0,1,2,3,4,5 -> at edge n+2 locked=1, pos=0, error=0.
REQ-030 Six further steps each showing a correct rotation -> pos steps 5,4,3,2,1,0 and rot_count=1 after the first (0->5).
REQ-031 In TRACK at pos=3, step with codes 0..5 (reload) -> pos=0, rot_count unchanged, error=0.
REQ-032 In TRACK, step with display4 at an invalid pattern -> code4=3'b111, error=1, locked=0; later steps leave error=1.
REQ-033 clear and step in the same cycle while in FAULT -> IDLE, all flags 0, codes 3'b111.
REQ-034 Steps in consecutive cycles -> second step ignored; rst_n dropped at edge n+1 -> no flag update.

Source files
------------

// File: rtl/letreiro_pkg.sv
// Shared constants, segment table and FSM state type for the marquee reader.
// The segment table holds the active-low gfedcba patterns of digits 0..5.
package letreiro_pkg;

    localparam int unsigned N_DISP       = 6;
    localparam logic [2:0]  CODE_INVALID = 3'b111;
    localparam logic [2:0]  CODE_LAST    = 3'd5;

    localparam logic [6:0] SEG_TABLE [0:5] = '{
        7'b100_0000,
        7'b111_1001,
        7'b010_0100,
        7'b011_0000,
        7'b001_1001,
        7'b001_0010
    };

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } state_e;

    // (c + 1) mod 6 for a valid code
    function automatic logic [2:0] code_succ(input logic [2:0] c);
        return (c == CODE_LAST) ? 3'd0 : c + 3'd1;
    endfunction

    // (c + 5) mod 6 for a valid code
    function automatic logic [2:0] code_pred(input logic [2:0] c);
        return (c == 3'd0) ? CODE_LAST : c - 3'd1;
    endfunction

endpackage

// File: rtl/seg_encoder.sv
// Combinational seven-segment pattern to code converter; unknown patterns give CODE_INVALID.
module seg_encoder
    import letreiro_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [2:0] code_o
);

    always_comb begin
        code_o = CODE_INVALID;
        for (int unsigned i = 0; i < 6; i++) begin
            if (pattern_i == SEG_TABLE[i]) begin
                code_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/leitor_letreiro.sv
// Marquee reader: captures six seven-segment displays on step, then one cycle later
// checks the captured codes against the expected rotation and updates the tracking flags.
module leitor_letreiro
    import letreiro_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       clear,
    input  logic [6:0] display1,
    input  logic [6:0] display2,
    input  logic [6:0] display3,
    input  logic [6:0] display4,
    input  logic [6:0] display5,
    input  logic [6:0] display6,
    output logic [2:0] code1,
    output logic [2:0] code2,
    output logic [2:0] code3,
    output logic [2:0] code4,
    output logic [2:0] code5,
    output logic [2:0] code6,
    output logic [2:0] pos,
    output logic       locked,
    output logic       error,
    output logic [7:0] rot_count
);

    logic [6:0] disp_w  [N_DISP];
    logic [2:0] dec_w   [N_DISP];
    logic [2:0] code_q  [N_DISP];
    logic       pending_q;

    state_e     state_q;
    logic [2:0] pos_q;
    logic       locked_q;
    logic       error_q;
    logic [7:0] rot_q;

    logic       consec;
    logic       is_rot;
    logic       is_reload;
    logic [2:0] pos_prev;

    assign disp_w[0] = display1;
    assign disp_w[1] = display2;
    assign disp_w[2] = display3;
    assign disp_w[3] = display4;
    assign disp_w[4] = display5;
    assign disp_w[5] = display6;

    for (genvar g = 0; g < N_DISP; g++) begin : g_enc
        seg_encoder u_enc (
            .pattern_i (disp_w[g]),
            .code_o    (dec_w[g])
        );
    end

    // Capture stage; a step is ignored while a compare is pending or in FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_DISP; i++) begin
                code_q[i] <= CODE_INVALID;
            end
            pending_q <= 1'b0;
        end else if (clear) begin
            for (int unsigned i = 0; i < N_DISP; i++) begin
                code_q[i] <= CODE_INVALID;
            end
            pending_q <= 1'b0;
        end else if (pending_q) begin
            pending_q <= 1'b0;
        end else if (step && (state_q != StFault)) begin
            for (int unsigned i = 0; i < N_DISP; i++) begin
                code_q[i] <= dec_w[i];
            end
            pending_q <= 1'b1;
        end
    end

    always_comb begin
        consec = 1'b1;
        for (int unsigned i = 0; i < N_DISP; i++) begin
            if (code_q[i] == CODE_INVALID) begin
                consec = 1'b0;
            end
        end
        for (int unsigned i = 0; i < N_DISP - 1; i++) begin
            if (code_q[i + 1] != code_succ(code_q[i])) begin
                consec = 1'b0;
            end
        end
    end

    assign pos_prev  = code_pred(pos_q);
    assign is_rot    = consec && (code_q[0] == pos_prev);
    assign is_reload = consec && (code_q[0] == 3'd0) && !is_rot;

    // Compare stage: acts only on the cycle after a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pos_q    <= 3'd0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            rot_q    <= 8'd0;
        end else if (clear) begin
            state_q  <= StIdle;
            pos_q    <= 3'd0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            rot_q    <= 8'd0;
        end else if (pending_q) begin
            unique case (state_q)
                StIdle: begin
                    if (consec) begin
                        state_q  <= StTrack;
                        pos_q    <= code_q[0];
                        locked_q <= 1'b1;
                    end
                end
                StTrack: begin
                    if (is_rot) begin
                        pos_q <= pos_prev;
                        // A full revolution ends when the wheel wraps from 0 to 5.
                        if ((pos_q == 3'd0) && (rot_q != 8'hFF)) begin
                            rot_q <= rot_q + 8'd1;
                        end
                    end else if (is_reload) begin
                        pos_q <= 3'd0;
                    end else begin
                        state_q  <= StFault;
                        locked_q <= 1'b0;
                        error_q  <= 1'b1;
                    end
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign code1     = code_q[0];
    assign code2     = code_q[1];
    assign code3     = code_q[2];
    assign code4     = code_q[3];
    assign code5     = code_q[4];
    assign code6     = code_q[5];
    assign pos       = pos_q;
    assign locked    = locked_q;
    assign error     = error_q;
    assign rot_count = rot_q;

endmodule

// File: tb/tb_leitor_letreiro.sv
// Randomized scoreboard bench for leitor_letreiro: a driver feeds a behavioural model and queues
// the expected outputs for every edge; a monitor pops and compares after each rising edge.
module tb_leitor_letreiro;

    logic       clk = 1'b1;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] disp [6];
    logic [6:0] nd   [6];
    logic [2:0] code1, code2, code3, code4, code5, code6, pos;
    logic       locked, error;
    logic [7:0] rot_count;

    always #5 clk = ~clk;

    leitor_letreiro dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .clear     (clear),
        .display1  (disp[0]),
        .display2  (disp[1]),
        .display3  (disp[2]),
        .display4  (disp[3]),
        .display5  (disp[4]),
        .display6  (disp[5]),
        .code1     (code1),
        .code2     (code2),
        .code3     (code3),
        .code4     (code4),
        .code5     (code5),
        .code6     (code6),
        .pos       (pos),
        .locked    (locked),
        .error     (error),
        .rot_count (rot_count)
    );

    // Digits 0..5, active-low gfedcba.
    logic [6:0] seg [6] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

    typedef struct {
        logic [17:0] codes;
        logic [2:0]  pos;
        logic        lk;
        logic        er;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Behavioural model: mode 0=idle, 1=tracking, 2=fault.
    int   m_mode = 0;
    int   m_pos = 0;
    int   m_lk = 0;
    int   m_er = 0;
    int   m_cnt = 0;
    int   m_pend = 0;
    int   m_code [6] = '{7, 7, 7, 7, 7, 7};

    function automatic int decode(input logic [6:0] p);
        for (int k = 0; k < 6; k++) if (p == seg[k]) return k;
        return 7;
    endfunction

    function automatic bit model_consec();
        for (int k = 0; k < 6; k++) if (m_code[k] == 7) return 1'b0;
        for (int k = 0; k < 5; k++) if (m_code[k + 1] != (m_code[k] + 1) % 6) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_lk = 0; m_er = 0; m_cnt = 0; m_pend = 0;
        for (int k = 0; k < 6; k++) m_code[k] = 7;
    endtask

    task automatic model_edge(input logic st, input logic cl, input logic rs);
        bit c;
        if (!rs || cl) begin
            model_reset();
        end else if (m_pend != 0) begin
            m_pend = 0;
            c = model_consec();
            if (m_mode == 0) begin
                if (c) begin m_mode = 1; m_pos = m_code[0]; m_lk = 1; end
            end else if (m_mode == 1) begin
                if (c && m_code[0] == (m_pos + 5) % 6) begin
                    if (m_pos == 0 && m_cnt < 255) m_cnt++;
                    m_pos = (m_pos + 5) % 6;
                end else if (c && m_code[0] == 0) begin
                    m_pos = 0;
                end else begin
                    m_mode = 2; m_lk = 0; m_er = 1;
                end
            end
        end else if (st && m_mode != 2) begin
            for (int k = 0; k < 6; k++) m_code[k] = decode(nd[k]);
            m_pend = 1;
        end
    endtask

    task automatic tick(input logic st, input logic cl, input logic rs);
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 6; k++) disp[k] = nd[k];
        step = st; clear = cl; rst_n = rs;
        model_edge(st, cl, rs);
        for (int k = 0; k < 6; k++) e.codes[17 - 3 * k -: 3] = 3'(m_code[k]);
        e.pos = 3'(m_pos); e.lk = 1'(m_lk); e.er = 1'(m_er); e.cnt = 8'(m_cnt);
        sbq.push_back(e);
    endtask

    task automatic set_seq(input int start);
        for (int k = 0; k < 6; k++) nd[k] = seg[(start + k) % 6];
    endtask

    task automatic do_step(input int start);
        set_seq(start);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: one scoreboard entry per rising edge.
    initial begin
        exp_t e;
        logic [17:0] got;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                got = {code1, code2, code3, code4, code5, code6};
                vectors++;
                if (got !== e.codes || pos !== e.pos || locked !== e.lk || error !== e.er
                    || rot_count !== e.cnt) begin
                    miscompares++;
                    $display("FAIL cycle %0d outputs: got codes=%h pos=%0d locked=%0b error=%0b cnt=%0d, want codes=%h pos=%0d locked=%0b error=%0b cnt=%0d",
                             cyc, got, pos, locked, error, rot_count,
                             e.codes, e.pos, e.lk, e.er, e.cnt);
                end
            end
        end
    end

    initial begin
        int r;
        int bad;
        logic st;
        set_seq(0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);

        // Lock, then one full revolution.
        do_step(0);
        for (int p = 5; p >= 0; p--) do_step(p);
        // Rotate to 3, then reload.
        do_step(5); do_step(4); do_step(3);
        do_step(0);
        // Invalid pattern on display4 forces a fault; later steps are ignored.
        set_seq(5); nd[3] = 7'h7F;
        tick(1'b1, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);
        do_step(0); do_step(5);
        // Clear together with step.
        set_seq(0);
        tick(1'b1, 1'b1, 1'b1); tick(1'b0, 1'b0, 1'b1);
        // Back-to-back steps: second is dropped.
        set_seq(2); tick(1'b1, 1'b0, 1'b1);
        set_seq(3); tick(1'b1, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);
        // Reset during a pending compare.
        do_step(0);
        set_seq(5); tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b1); tick(1'b0, 1'b0, 1'b1);

        // Saturation of the revolution counter.
        do_step(0);
        for (int n = 0; n < 258 * 6; n++) do_step((m_pos + 5) % 6);

        // Random mix.
        tick(1'b0, 1'b1, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      set_seq((m_pos + 5) % 6);
            else if (r < 55) set_seq(0);
            else if (r < 70) set_seq($urandom_range(0, 5));
            else begin
                set_seq($urandom_range(0, 5));
                bad = $urandom_range(0, 5);
                nd[bad] = ($urandom_range(0, 1) == 0) ? 7'($urandom) : seg[$urandom_range(0, 5)];
            end
            st = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 99);
            if (r < 2)                       tick(st, 1'b0, 1'b0);
            else if (r < 6 || (m_mode == 2 && r < 20)) tick(st, 1'b1, 1'b1);
            else                             tick(st, 1'b0, 1'b1);
        end
        tick(1'b0, 1'b0, 1'b1);

        for (int w = 0; w < 20 && sbq.size() > 0; w++) @(posedge clk);
        @(negedge clk);
        if (sbq.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
